// File: rtl/bpred_pkg.sv
// bpred_pkg
// Shared widths for the branch-predictor storage.
//   HOB_W   : perceptron high-order-bit word (3 bits x 12 history weights)
//   LOB_W   : perceptron low-order-bit word  (5 bits x 12 history weights)
//   INSN_W  : fetch instruction word
//   BP_AW   : predictor table index (PC[7:2])
//   INSN_AW : instruction memory index (PC[9:2])
package bpred_pkg;

  localparam int HOB_W   = 36;
  localparam int LOB_W   = 60;
  localparam int INSN_W  = 32;
  localparam int BP_AW   = 6;
  localparam int INSN_AW = 8;

endpackage

// File: rtl/bpred_sdp_ram.sv
// bpred_sdp_ram
// Simple-dual-port synchronous RAM: one write port and one registered read port.
// This block backs the HOB, complemented-HOB, LOB and instruction memories.
//
// Parameters:
//   DATA_WIDTH : word width (default INSN_W = 32)
//   ADDR_WIDTH : address width, depth = 2**ADDR_WIDTH (default INSN_AW = 8)
// Ports:
//   clock      : rising-edge clock
//   reset      : async active-high; clears the read register(s) only
//   data       : write data
//   wraddress  : write address
//   wren       : write enable
//   rdaddress  : read address, sampled every edge
//   q          : registered read data
// Configuration macro:
//   BPRED_RAM_OUTREG_EN : adds a second output register (2-cycle read latency)
module bpred_sdp_ram
  import bpred_pkg::*;
#(
  parameter int DATA_WIDTH = INSN_W,
  parameter int ADDR_WIDTH = INSN_AW
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Power-up contents are zero; reset never touches the array.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_q1;

  // Writes ignore reset so tables can be initialised while reset is held.
  always_ff @(posedge clock) begin
    if (wren) begin
      r_mem[wraddress] <= data;
    end
  end

  // Non-blocking read of the array gives old data on a same-address write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q1 <= '0;
    end else begin
      r_q1 <= r_mem[rdaddress];
    end
  end

`ifdef BPRED_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_q2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q2 <= '0;
    end else begin
      r_q2 <= r_q1;
    end
  end

  assign q = r_q2;
`else
  assign q = r_q1;
`endif

endmodule

// File: tb/tb_bpred_sdp_ram.sv
module tb_bpred_sdp_ram;

`ifdef BPRED_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic [7:0]  wraddress;
  logic        wren;
  logic [7:0]  rdaddress;
  logic [31:0] q;

  logic [59:0] w_data;
  logic [5:0]  w_wraddress;
  logic        w_wren;
  logic [5:0]  w_rdaddress;
  logic [59:0] w_q;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bpred_sdp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .q         (q)
  );

  bpred_sdp_ram #(.DATA_WIDTH(60), .ADDR_WIDTH(6)) u_wide (
    .clock     (clock),
    .reset     (reset),
    .data      (w_data),
    .wraddress (w_wraddress),
    .wren      (w_wren),
    .rdaddress (w_rdaddress),
    .q         (w_q)
  );

  typedef struct {
    string       name;
    logic        wren;
    logic [7:0]  wraddr;
    logic [31:0] wdata;
    logic [7:0]  rdaddr;
    logic [31:0] exp_q;   // value on q after this edge with a single stage
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_main(input string name, input logic [7:0] a, input logic [31:0] exp);
    wren = 1'b0;
    rdaddress = a;
    for (int k = 0; k < LAT; k++) step();
    chk(name, {32'h0, q}, {32'h0, exp});
  endtask

  task automatic rd_wide(input string name, input logic [5:0] a, input logic [59:0] exp);
    w_wren = 1'b0;
    w_rdaddress = a;
    for (int k = 0; k < LAT; k++) step();
    chk(name, {4'h0, w_q}, {4'h0, exp});
  endtask

  initial begin
    vecs[0] = '{"pwrup_rd05",  1'b0, 8'h00, 32'h0,        8'h05, 32'h00000000};
    vecs[1] = '{"rd_ff_rst_wr",1'b1, 8'h10, 32'hDEADBEEF, 8'hFF, 32'h0000ABCD};
    vecs[2] = '{"rd_10",       1'b0, 8'h00, 32'h0,        8'h10, 32'hDEADBEEF};
    vecs[3] = '{"wr20_rd10",   1'b1, 8'h20, 32'h11111111, 8'h10, 32'hDEADBEEF};
    vecs[4] = '{"rdw_old",     1'b1, 8'h20, 32'h22222222, 8'h20, 32'h11111111};
    vecs[5] = '{"rdw_new",     1'b0, 8'h00, 32'h0,        8'h20, 32'h22222222};
    vecs[6] = '{"wr30_rd20",   1'b1, 8'h30, 32'h55AA55AA, 8'h20, 32'h22222222};
    vecs[7] = '{"wr31_rd30",   1'b1, 8'h31, 32'h12345678, 8'h30, 32'h55AA55AA};
    vecs[8] = '{"rd_31",       1'b0, 8'h00, 32'h0,        8'h31, 32'h12345678};
    vecs[9] = '{"rd_00",       1'b0, 8'h00, 32'h0,        8'h00, 32'h00000000};

    reset = 1'b1;
    data = '0; wraddress = '0; wren = 1'b0; rdaddress = '0;
    w_data = '0; w_wraddress = '0; w_wren = 1'b0; w_rdaddress = '0;
    #1;
    chk("reset_q0", {32'h0, q}, 64'h0);

    // Write during reset; q must stay 0 the whole time.
    wren = 1'b1; wraddress = 8'hFF; data = 32'h0000ABCD; rdaddress = 8'hFF;
    step();
    chk("rst_hold_q0_a", {32'h0, q}, 64'h0);
    wren = 1'b0;
    step();
    chk("rst_hold_q0_b", {32'h0, q}, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      int j;
      wren = vecs[i].wren;
      wraddress = vecs[i].wraddr;
      data = vecs[i].wdata;
      rdaddress = vecs[i].rdaddr;
      step();
      j = i - LAT + 1;
      if (j >= 0) chk(vecs[j].name, {32'h0, q}, {32'h0, vecs[j].exp_q});
    end

    // q only changes on an edge.
    wren = 1'b0;
    rdaddress = 8'h10;
    for (int k = 0; k < LAT; k++) step();
    chk("rd10_again", {32'h0, q}, {32'h0, 32'hDEADBEEF});
    rdaddress = 8'h30;
    #2;
    chk("no_comb_path", {32'h0, q}, {32'h0, 32'hDEADBEEF});
    rdaddress = 8'h10;

    // Async reset between edges.
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_q0", {32'h0, q}, 64'h0);
    step();
    chk("async_rst_hold", {32'h0, q}, 64'h0);
    reset = 1'b0;
    rd_main("mem_kept_10", 8'h10, 32'hDEADBEEF);
    rd_main("mem_kept_ff", 8'hFF, 32'h0000ABCD);

    // Wide instance: top address and address 0, full width.
    w_wren = 1'b1; w_wraddress = 6'd63; w_data = 60'hFFF_FFFF_FFFF_FFFF;
    step();
    w_wraddress = 6'd0; w_data = 60'h1;
    step();
    w_wren = 1'b0;
    rd_wide("wide_rd63", 6'd63, 60'hFFF_FFFF_FFFF_FFFF);
    rd_wide("wide_rd0", 6'd0, 60'h1);
    rd_wide("wide_rd1", 6'd1, 60'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpred_sdp_ram.md
# bpred_sdp_ram

Generic simple-dual-port synchronous RAM with one write port and one read port. Provides the branch-predictor storage: perceptron high-order-bit tables (36-bit × 64), low-order-bit table (60-bit × 64) and the fetch instruction memory (32-bit × 256). Sits beside the fetch/predict stage. The read address is supplied before a clock edge and the data is used after it.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width in bits.
- `ADDR_WIDTH`, default 8: address width. Depth is 2^ADDR_WIDTH words.

Ports:
- `clock` in 1: single clock. All sampling is on its rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `data` in DATA_WIDTH: write data.
- `wraddress` in ADDR_WIDTH: write address.
- `wren` in 1: write enable.
- `rdaddress` in ADDR_WIDTH: read address.
- `q` out DATA_WIDTH: registered read data.

## Operation
- Storage is an array of 2^ADDR_WIDTH words.
  - All words are zero at power-up (initialised contents).
  - `reset` does not clear the array.
- Write:
  - On a rising edge with `wren`=1, `mem[wraddress] <= data`.
  - Writes are accepted even while `reset` is asserted, so the predictor can initialise its tables during reset.
- Read:
  - On every rising edge with `reset`=0, `q <= mem[rdaddress]`.
  - There is no read enable. `q` follows the address every cycle.
- Read-during-write to the same address on the same edge returns the OLD word. The new word is visible from the next read.
- Simultaneous writes to different addresses than the read address have no interaction.
- Address space is fully decoded, so there are no out-of-range addresses. `rdaddress`/`wraddress` wrap naturally at 2^ADDR_WIDTH.
- Reset:
  - `q` is forced to 0 asynchronously the moment `reset` rises.
  - `q` holds 0 while `reset` is high.
  - Memory contents are preserved.

## Timing
- Read latency is 1 cycle. `rdaddress` sampled at edge N appears on `q` after edge N and is stable through cycle N+1.
- Write latency: data written at edge N is readable by a `rdaddress` sampled at edge N+1 or later.
- `reset` deassertion:
  - The first edge with `reset`=0 loads `q`.
  - Until that edge, `q`=0.
- A mid-operation reset discards the in-flight read (`q`→0). It does not abort a write that occurs on the same edge.
- The output is driven only by flops; there is no combinational path from inputs to `q`.

## Configuration
- Macro `BPRED_RAM_OUTREG_EN`.
- When defined:
  - A second output register stage is added, giving a read latency of 2 cycles.
  - Both stages are async-cleared by `reset`.
  - Read-during-write returns old data, relative to the first stage.
- When undefined: single-stage behaviour exactly as above, with 1-cycle latency.

## Structure
- Shared package `bpred_pkg` holds:
  - `HOB_W`=36 and `LOB_W`=60 (hob=3 and lob=5 bits × 12 history weights).
  - `INSN_W`=32.
  - `BP_AW`=6 (PC[7:2]) and `INSN_AW`=8 (PC[9:2]).
- No sub-module. The three predictor memories are plain instances of this block, parameterised from `bpred_pkg`:
  - HOB table: (36, 6)
  - complemented-HOB table: (36, 6)
  - LOB table: (60, 6)
  - instruction memory: (32, 8)

## Test plan
Run with DATA_WIDTH=32 and ADDR_WIDTH=8 unless noted.
- Power-up read: `reset` pulse, then `rdaddress`=0x05 with no prior writes -> `q`=0x00000000 one cycle later.
- Write/read: write 0xDEADBEEF to 0x10, then on the next cycle `rdaddress`=0x10 -> `q`=0xDEADBEEF after that edge. With `BPRED_RAM_OUTREG_EN`, it appears one edge later.
- Read-during-write:
  - Setup: `mem[0x20]`=0x11111111.
  - Stimulus: write 0x22222222 to 0x20 with `rdaddress`=0x20 on the same edge.
  - Required: `q`=0x11111111, then 0x22222222 on the following edge.
- Async reset mid-stream:
  - Stimulus: `q`=0xDEADBEEF; raise `reset` between edges.
  - Required: `q`=0 immediately, and `mem[0x10]` still reads 0xDEADBEEF after release.
- Write during reset:
  - Stimulus: with `reset`=1, write 0x0000ABCD to 0xFF; release reset and read 0xFF.
  - Required: `q`=0x0000ABCD, and `q`=0 throughout the reset period.
- Wide instance (DATA_WIDTH=60, ADDR_WIDTH=6):
  - Stimulus: write 60'hFFF_FFFF_FFFF_FFFF to 63 and 60'h1 to 0; read 63 then 0.
  - Required: exact words returned, confirming address wrap and full width.
